operand_entry: RTL and testbench

Sequential front end for the four-digit calculator stage. Collects two 2-digit BCD operands and a 2-bit operator from one 4-bit switch group and debounced pushbuttons, and presents them as an 18-bit word in the calculator's switch layout. Sits directly upstream of the calculator, replacing direct switch drive of its 18-bit input.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/operand_entry.sv | 96 +++++++++
 tb/tb_operand_entry.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared operator codes, word layout and entry state encoding
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int WORD_W = 18;
  localparam int POS_A1 = 14;
  localparam int POS_A0 = 10;
  localparam int POS_B1 = 6;
  localparam int POS_B0 = 2;
  localparam int POS_OP = 0;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Digit states are 0..3 so the low two bits double as a digit index.
  typedef enum logic [2:0] {
    ST_A1   = 3'd0,
    ST_A0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B0   = 3'd3,
    ST_OP   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  function automatic logic [4:0] cursor_of(state_t s);
    case (s)
      ST_A1:   cursor_of = 5'b10000;
      ST_A0:   cursor_of = 5'b01000;
      ST_B1:   cursor_of = 5'b00100;
      ST_B0:   cursor_of = 5'b00010;
      ST_OP:   cursor_of = 5'b00001;
      default: cursor_of = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, debounce counter and one-cycle press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples already disagreed with level;
  // the DEBOUNCE_CYCLES-th disagreeing sample flips the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-operand BCD entry FSM; ENTRY_ECHO_EN enables live echo of partial entry
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw_val,
  input  logic        btn_next_n,
  input  logic        btn_clear_n,
  output logic [17:0] calc_word,
  output logic        word_valid,
  output logic [4:0]  cursor,
  output logic        entry_err
);

  logic next_p;
  logic clr_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_next_n),
    .press (next_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_clear_n),
    .press (clr_p)
  );

  state_t          state;
  logic [3:0][3:0] digits;
  logic [3:0][3:0] digits_nx;
  state_t          state_nx;

  // digits[3] is A tens so the packed array concatenates straight into the word.
  always_comb begin
    digits_nx = digits;
    digits_nx[2'd3 - state[1:0]] = sw_val;
    state_nx = state_t'(state + 3'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_A1;
      digits     <= '0;
      calc_word  <= '0;
      word_valid <= 1'b0;
      cursor     <= cursor_of(ST_A1);
      entry_err  <= 1'b0;
    end else if (clr_p) begin
      state      <= ST_A1;
      digits     <= '0;
      calc_word  <= '0;
      word_valid <= 1'b0;
      cursor     <= cursor_of(ST_A1);
      entry_err  <= 1'b0;
    end else if (next_p) begin
      case (state)
        ST_A1, ST_A0, ST_B1, ST_B0: begin
          if (sw_val <= BCD_MAX) begin
            digits    <= digits_nx;
            entry_err <= 1'b0;
            state     <= state_nx;
            cursor    <= cursor_of(state_nx);
`ifdef ENTRY_ECHO_EN
            calc_word <= {digits_nx, 2'b00};
`endif
          end else begin
            entry_err <= 1'b1;
          end
        end
        ST_OP: begin
          calc_word  <= {digits, sw_val[1:0]};
          word_valid <= 1'b1;
          entry_err  <= 1'b0;
          state      <= ST_DONE;
          cursor     <= cursor_of(ST_DONE);
        end
        default: begin
          // A press in DONE only restarts entry; sw_val is ignored.
          state      <= ST_A1;
          digits     <= '0;
          calc_word  <= '0;
          word_valid <= 1'b0;
          cursor     <= cursor_of(ST_A1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - self-checking bench for operand_entry with DEBOUNCE_CYCLES = 4
module tb_operand_entry;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sw_val = 4'd0;
  logic        btn_next_n = 1'b1;
  logic        btn_clear_n = 1'b1;
  logic [17:0] calc_word;
  logic        word_valid;
  logic [4:0]  cursor;
  logic        entry_err;

  int n_checks = 0;
  int n_fail = 0;

  operand_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_val      (sw_val),
    .btn_next_n  (btn_next_n),
    .btn_clear_n (btn_clear_n),
    .calc_word   (calc_word),
    .word_valid  (word_valid),
    .cursor      (cursor),
    .entry_err   (entry_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button channels as delayed sample streams with a run
  // length rule, and the entry sequence as a field index plus value table.
  bit         raw_d1 [2];
  bit         raw_d2 [2];
  bit         acc    [2];
  int         run    [2];
  bit         pend_n;
  bit         pend_c;
  logic [3:0] f [5];
  int         idx;
  bit         v_m;
  bit         e_m;
  logic [17:0] w_m;

  function automatic logic [17:0] pack_fields();
    return {f[0], f[1], f[2], f[3], f[4][1:0]};
  endfunction

  function automatic bit step(int ch, bit raw);
    bit pressed = 1'b0;
    if (raw_d2[ch] != acc[ch]) begin
      run[ch]++;
      if (run[ch] == N) begin
        acc[ch] = raw_d2[ch];
        run[ch] = 0;
        pressed = (raw_d2[ch] == 1'b0);
      end
    end else begin
      run[ch] = 0;
    end
    raw_d2[ch] = raw_d1[ch];
    raw_d1[ch] = raw;
    return pressed;
  endfunction

  function automatic void clear_fields();
    for (int i = 0; i < 5; i++) f[i] = 4'd0;
    idx = 0;
    v_m = 1'b0;
    w_m = '0;
  endfunction

  function automatic void model_next(logic [3:0] v);
    if (idx < 4) begin
      if (v <= 4'd9) begin
        f[idx] = v;
        e_m = 1'b0;
        idx++;
`ifdef ENTRY_ECHO_EN
        w_m = pack_fields();
`endif
      end else begin
        e_m = 1'b1;
      end
    end else if (idx == 4) begin
      f[4] = {2'b00, v[1:0]};
      e_m = 1'b0;
      idx = 5;
      v_m = 1'b1;
      w_m = pack_fields();
    end else begin
      clear_fields();
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      raw_d1[c] = 1'b1;
      raw_d2[c] = 1'b1;
      acc[c] = 1'b1;
      run[c] = 0;
    end
    pend_n = 1'b0;
    pend_c = 1'b0;
    e_m = 1'b0;
    clear_fields();
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        if (pend_c) begin
          clear_fields();
          e_m = 1'b0;
        end else if (pend_n) begin
          model_next(sw_val);
        end
        pend_n = step(0, btn_next_n);
        pend_c = step(1, btn_clear_n);
      end
    end
  end

  always @(negedge clk) begin
    chk("model_calc_word", calc_word, w_m);
    chk("model_word_valid", {17'd0, word_valid}, {17'd0, v_m});
    chk("model_cursor", {13'd0, cursor}, {13'd0, (idx == 5) ? 5'b00000 : (5'b10000 >> idx)});
    chk("model_entry_err", {17'd0, entry_err}, {17'd0, e_m});
  end

  task automatic press_next(input logic [3:0] v);
    @(negedge clk);
    sw_val = v;
    btn_next_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_both(input logic [3:0] v);
    @(negedge clk);
    sw_val = v;
    btn_next_n = 1'b0;
    btn_clear_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_next_n = 1'b1;
    btn_clear_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk);
    btn_clear_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_clear_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_word"}, calc_word, 18'd0);
    chk({tag, "_valid"}, {17'd0, word_valid}, 18'd0);
    chk({tag, "_cursor"}, {13'd0, cursor}, {13'd0, 5'b10000});
    chk({tag, "_err"}, {17'd0, entry_err}, 18'd0);
  endtask

  logic [7:0] echo_exp;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("reset");

    press_next(4'd1);
    press_next(4'd2);
    press_next(4'd3);
    press_next(4'd4);
    press_next(4'd2);
    chk("full_word", calc_word, 18'b0001_0010_0011_0100_10);
    chk("full_valid", {17'd0, word_valid}, 18'd1);
    chk("full_cursor", {13'd0, cursor}, 18'd0);

    press_next(4'd6);
    chk_reset_values("done_restart");

    // Bounce shorter than the debounce window, then a long hold.
    @(negedge clk);
    sw_val = 4'd7;
    for (int i = 0; i < 5; i++) begin
      btn_next_n = 1'b0;
      repeat (2) @(negedge clk);
      btn_next_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    btn_next_n = 1'b0;
    repeat (30) @(negedge clk);
    btn_next_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_cursor", {13'd0, cursor}, {13'd0, 5'b01000});

    press_next(4'd12);
    chk("range_err_set", {17'd0, entry_err}, 18'd1);
    chk("range_cursor_stay", {13'd0, cursor}, {13'd0, 5'b01000});
    press_next(4'd5);
    chk("range_err_clear", {17'd0, entry_err}, 18'd0);
    chk("range_cursor_adv", {13'd0, cursor}, {13'd0, 5'b00100});

    press_clear();
    chk_reset_values("clear_btn");
    press_next(4'd7);
    press_next(4'd3);
`ifdef ENTRY_ECHO_EN
    echo_exp = 8'b0111_0011;
`else
    echo_exp = 8'b0000_0000;
`endif
    chk("echo_a_field", {10'd0, calc_word[17:10]}, {10'd0, echo_exp});
    chk("echo_valid_low", {17'd0, word_valid}, 18'd0);

    press_both(4'd6);
    chk_reset_values("clear_wins");
    press_next(4'd9);
    chk("after_clear_cursor", {13'd0, cursor}, {13'd0, 5'b01000});
    press_next(4'd8);
    press_next(4'd1);
    chk("b0_cursor", {13'd0, cursor}, {13'd0, 5'b00010});

    @(negedge clk);
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    @(negedge clk);
    chk_reset_values("mid_reset");

    press_next(4'd10);
    chk("ten_err", {17'd0, entry_err}, 18'd1);
    chk("ten_cursor", {13'd0, cursor}, {13'd0, 5'b10000});
    press_next(4'd9);
    press_next(4'd9);
    press_next(4'd9);
    press_next(4'd9);
    press_next(4'd3);
    chk("div_word", calc_word, 18'b1001_1001_1001_1001_11);
    chk("div_valid", {17'd0, word_valid}, 18'd1);
    chk("div_err", {17'd0, entry_err}, 18'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
